// File: rtl/ast_dmx_package.sv
// Shared types for the Avalon-ST direction classifier: FSM state encoding and
// the per-channel lookup table entry.
package ast_dmx_package;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } cls_state_e;

  // Entries carry the widest supported direction select; narrower configs zero-extend.
  localparam int unsigned DIR_W_MAX = 8;

  typedef struct packed {
    logic                 en;
    logic [DIR_W_MAX-1:0] dir;
  } tbl_entry_t;

  function automatic tbl_entry_t mk_entry(input logic en, input logic [DIR_W_MAX-1:0] dir);
    tbl_entry_t e;
    e.en  = en;
    e.dir = dir;
    return e;
  endfunction

endpackage

// File: rtl/ast_dir_cls_tbl.sv
// Channel-to-direction lookup table: synchronous write, combinational read,
// all entries cleared (en=0) by reset.
module ast_dir_cls_tbl
  import ast_dmx_package::*;
#(
  parameter int CHANNEL_WIDTH = 8,
  parameter int DIR_SEL_WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_i,
  input  logic [CHANNEL_WIDTH-1:0] wr_idx_i,
  input  logic [DIR_SEL_WIDTH-1:0] wr_dir_i,
  input  logic                     wr_en_i,
  input  logic [CHANNEL_WIDTH-1:0] rd_idx_i,
  output tbl_entry_t               rd_entry_o
);

  localparam int unsigned DEPTH = 2 ** CHANNEL_WIDTH;

  tbl_entry_t mem_r [DEPTH];

  // Table storage; a read in the write cycle still returns the old entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_i) begin
      mem_r[wr_idx_i] <= mk_entry(wr_en_i, DIR_W_MAX'(wr_dir_i));
    end
  end

  assign rd_entry_o = mem_r[rd_idx_i];

endmodule

// File: rtl/ast_dir_cls.sv
// Avalon-ST direction classifier: looks up each packet's channel at sop, forwards
// mapped packets through one output register with a stable dir_o, drops the rest.
module ast_dir_cls
  import ast_dmx_package::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int CHANNEL_WIDTH = 8,
  parameter int TX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_WIDTH-1:0]    ast_data_i,
  input  logic                     ast_startofpacket_i,
  input  logic                     ast_endofpacket_i,
  input  logic                     ast_valid_i,
  input  logic [EMPTY_WIDTH-1:0]   ast_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] ast_channel_i,
  output logic                     ast_ready_o,
  output logic [DATA_WIDTH-1:0]    ast_data_o,
  output logic                     ast_startofpacket_o,
  output logic                     ast_endofpacket_o,
  output logic                     ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0] ast_channel_o,
  input  logic                     ast_ready_i,
  output logic [DIR_SEL_WIDTH-1:0] dir_o,
  input  logic                     cfg_wr_i,
  input  logic [CHANNEL_WIDTH-1:0] cfg_chan_i,
  input  logic [DIR_SEL_WIDTH-1:0] cfg_dir_i,
  input  logic                     cfg_en_i,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o,
  output logic [CNT_WIDTH-1:0]     err_cnt_o
);

  cls_state_e               state_r, state_nxt_s;
  tbl_entry_t               lk_entry_s;
  logic                     tbl_unused_s;
  logic                     rdy_en_r;
  logic                     ready_s;
  logic                     accept_s;
  logic                     load_s;
  logic                     load_dir_s;
  logic                     drop_inc_s;
  logic                     err_inc_s;
  logic [DATA_WIDTH-1:0]    data_r;
  logic                     sop_r;
  logic                     eop_r;
  logic                     valid_r;
  logic [EMPTY_WIDTH-1:0]   empty_r;
  logic [CHANNEL_WIDTH-1:0] chan_r;
  logic [DIR_SEL_WIDTH-1:0] dir_r;
  logic [CNT_WIDTH-1:0]     drop_cnt_r;
  logic [CNT_WIDTH-1:0]     err_cnt_r;

  ast_dir_cls_tbl #(
    .CHANNEL_WIDTH (CHANNEL_WIDTH),
    .DIR_SEL_WIDTH (DIR_SEL_WIDTH)
  ) u_tbl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_i       (cfg_wr_i),
    .wr_idx_i   (cfg_chan_i),
    .wr_dir_i   (cfg_dir_i),
    .wr_en_i    (cfg_en_i),
    .rd_idx_i   (ast_channel_i),
    .rd_entry_o (lk_entry_s)
  );

  // Bits above DIR_SEL_WIDTH are always zero in the table.
  assign tbl_unused_s = ^lk_entry_s;

  // Upstream ready: held low until the first edge after reset, always open in DROP.
  always_comb begin
    ready_s = 1'b0;
    if (!rdy_en_r) begin
      ready_s = 1'b0;
    end else if (state_r == ST_DROP) begin
      ready_s = 1'b1;
    end else begin
      ready_s = !valid_r || ast_ready_i;
    end
  end

  assign accept_s = ast_valid_i && ready_s;

  // Next-state and per-beat actions.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    load_dir_s  = 1'b0;
    drop_inc_s  = 1'b0;
    err_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (ast_startofpacket_i) begin
            if (lk_entry_s.en) begin
              load_s      = 1'b1;
              load_dir_s  = 1'b1;
              state_nxt_s = ast_endofpacket_i ? ST_IDLE : ST_FWD;
            end else begin
              drop_inc_s  = 1'b1;
              state_nxt_s = ast_endofpacket_i ? ST_IDLE : ST_DROP;
            end
          end else begin
            err_inc_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (accept_s) begin
          load_s      = 1'b1;
          err_inc_s   = ast_startofpacket_i;
          state_nxt_s = ast_endofpacket_i ? ST_IDLE : ST_FWD;
        end else begin
          state_nxt_s = ST_FWD;
        end
      end
      ST_DROP: begin
        if (accept_s && ast_endofpacket_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and post-reset ready enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      rdy_en_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rdy_en_r <= 1'b1;
    end
  end

  // Output register; dir only moves on a packet-opening sop so it spans the packet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      empty_r <= '0;
      chan_r  <= '0;
      dir_r   <= '0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      data_r  <= ast_data_i;
      sop_r   <= ast_startofpacket_i;
      eop_r   <= ast_endofpacket_i;
      empty_r <= ast_empty_i;
      chan_r  <= ast_channel_i;
      if (load_dir_s) begin
        dir_r <= lk_entry_s.dir[DIR_SEL_WIDTH-1:0];
      end
    end else if (ast_ready_i) begin
      valid_r <= 1'b0;
    end
  end

  // Saturating drop and error counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_r <= '0;
      err_cnt_r  <= '0;
    end else begin
      if (drop_inc_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
      end
      if (err_inc_s && (err_cnt_r != {CNT_WIDTH{1'b1}})) begin
        err_cnt_r <= err_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  assign ast_ready_o         = ready_s;
  assign ast_valid_o         = valid_r;
  assign ast_data_o          = data_r;
  assign ast_startofpacket_o = sop_r;
  assign ast_endofpacket_o   = eop_r;
  assign ast_empty_o         = empty_r;
  assign ast_channel_o       = chan_r;
  assign dir_o               = dir_r;
  assign drop_cnt_o          = drop_cnt_r;
  assign err_cnt_o           = err_cnt_r;

endmodule

// File: tb/tb_ast_dir_cls.sv
// Directed testbench for ast_dir_cls with a scoreboard of expected output beats.
module tb_ast_dir_cls;

  localparam int DW   = 64;
  localparam int EW   = 3;
  localparam int CW   = 8;
  localparam int DSW  = 2;
  localparam int CNTW = 4;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic           sop;
    logic           eop;
    logic [EW-1:0]  empty;
    logic [CW-1:0]  ch;
    logic [DSW-1:0] dir;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [DW-1:0]   ast_data_i = '0;
  logic            ast_startofpacket_i = 1'b0;
  logic            ast_endofpacket_i = 1'b0;
  logic            ast_valid_i = 1'b0;
  logic [EW-1:0]   ast_empty_i = '0;
  logic [CW-1:0]   ast_channel_i = '0;
  logic            ast_ready_o;
  logic [DW-1:0]   ast_data_o;
  logic            ast_startofpacket_o;
  logic            ast_endofpacket_o;
  logic            ast_valid_o;
  logic [EW-1:0]   ast_empty_o;
  logic [CW-1:0]   ast_channel_o;
  logic            ast_ready_i = 1'b1;
  logic [DSW-1:0]  dir_o;
  logic            cfg_wr_i = 1'b0;
  logic [CW-1:0]   cfg_chan_i = '0;
  logic [DSW-1:0]  cfg_dir_i = '0;
  logic            cfg_en_i = 1'b0;
  logic [CNTW-1:0] drop_cnt_o;
  logic [CNTW-1:0] err_cnt_o;

  beat_t         exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            lat_req = 0;
  int            lat_stage = 0;
  logic [DW-1:0] lat_dat = '0;
  logic [DW-1:0] lat_stage_dat = '0;
  logic          hold_v = 1'b0;
  beat_t         hold_b;
  int            w;

  ast_dir_cls #(
    .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW),
    .TX_DIR(4), .DIR_SEL_WIDTH(DSW), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i),
    .ast_ready_o(ast_ready_o),
    .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
    .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o),
    .ast_ready_i(ast_ready_i), .dir_o(dir_o),
    .cfg_wr_i(cfg_wr_i), .cfg_chan_i(cfg_chan_i), .cfg_dir_i(cfg_dir_i), .cfg_en_i(cfg_en_i),
    .drop_cnt_o(drop_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_beat(input beat_t e);
    chk("out_data", ast_data_o, e.data);
    chk("out_sop", 64'(ast_startofpacket_o), 64'(e.sop));
    chk("out_eop", 64'(ast_endofpacket_o), 64'(e.eop));
    chk("out_empty", 64'(ast_empty_o), 64'(e.empty));
    chk("out_channel", 64'(ast_channel_o), 64'(e.ch));
    chk("out_dir", 64'(dir_o), 64'(e.dir));
  endtask

  // Output monitor: latency, hold stability and in-order beat comparison.
  always @(negedge clk) begin
    if (!rst_ni) begin
      hold_v <= 1'b0;
    end else begin
      if (lat_stage == 1) begin
        chk("latency_valid", 64'(ast_valid_o), 64'd1);
        chk("latency_data", ast_data_o, lat_stage_dat);
      end else if (lat_stage == 2) begin
        chk("dropped_no_output", 64'(ast_valid_o), 64'd0);
      end
      if (hold_v) begin
        chk("hold_valid", 64'(ast_valid_o), 64'd1);
        chk("hold_data", ast_data_o, hold_b.data);
        chk("hold_dir", 64'(dir_o), 64'(hold_b.dir));
      end
      if (ast_valid_o && ast_ready_i) begin
        n_chk++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_beat: observed data %0h, expected no beat", ast_data_o);
        end
        if (exp_q.size() > 0) mon_beat(exp_q.pop_front());
      end
      hold_v <= ast_valid_o && !ast_ready_i;
      hold_b <= '{ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o, dir_o};
    end
  end

  always @(posedge clk) begin
    lat_stage     <= lat_req;
    lat_stage_dat <= lat_dat;
  end

  // mode: 1 = forwarded (scoreboarded), 2 = dropped with idle output, 0 = discarded unchecked
  task automatic send(input beat_t b, input int mode, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    ast_valid_i = 1'b1;
    ast_data_i = b.data;
    ast_startofpacket_i = b.sop;
    ast_endofpacket_i = b.eop;
    ast_empty_i = b.empty;
    ast_channel_i = b.ch;
    while (!acc && waits < 50) begin
      @(negedge clk);
      if (ast_ready_o) acc = 1'b1;
      else waits++;
    end
    n_chk++;
    assert (acc) else begin
      n_err++;
      $error("FAIL accept_timeout: observed waits %0d expected acceptance", waits);
    end
    if (acc) begin
      if (mode == 1) exp_q.push_back(b);
      lat_req = mode;
      lat_dat = b.data;
    end
    @(posedge clk);
    #1;
    lat_req = 0;
    ast_valid_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [CW-1:0] ch, input logic [DSW-1:0] dir, input logic en);
    cfg_wr_i = 1'b1;
    cfg_chan_i = ch;
    cfg_dir_i = dir;
    cfg_en_i = en;
    @(posedge clk);
    #1;
    cfg_wr_i = 1'b0;
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic s, input logic e,
                               input logic [CW-1:0] ch, input logic [DSW-1:0] dir);
    beat_t b;
    b.data = d;
    b.sop = s;
    b.eop = e;
    b.empty = e ? 3'd5 : 3'd0;
    b.ch = ch;
    b.dir = dir;
    return b;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(ast_valid_o), 64'd0);
    chk({tag, "_sop_eop"}, 64'({ast_startofpacket_o, ast_endofpacket_o}), 64'd0);
    chk({tag, "_data"}, ast_data_o, 64'd0);
    chk({tag, "_empty_chan"}, 64'({ast_empty_o, ast_channel_o}), 64'd0);
    chk({tag, "_dir"}, 64'(dir_o), 64'd0);
    chk({tag, "_cnts"}, 64'({drop_cnt_o, err_cnt_o}), 64'd0);
    chk({tag, "_ready"}, 64'(ast_ready_o), 64'd0);
  endtask

  initial begin
    // Reset state and ready release timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", 64'(ast_ready_o), 64'd0);
    @(negedge clk);
    chk("ready_after_first_edge", 64'(ast_ready_o), 64'd1);
    @(posedge clk); #1;

    cfg_write(8'd5, 2'd2, 1'b1);
    cfg_write(8'd1, 2'd1, 1'b1);

    // 4-beat packet on mapped ch 5
    for (int i = 0; i < 4; i++) send(mk(64'h5500 + 64'(i), i == 0, i == 3, 8'd5, 2'd2), 1, w);

    // 3-beat packet on unmapped ch 9, accepted immediately every beat
    for (int i = 0; i < 3; i++) begin
      send(mk(64'h9900 + 64'(i), i == 0, i == 2, 8'd9, 2'd0), 2, w);
      chk("drop_ready_immediate", 64'(w), 64'd0);
    end
    chk("drop_cnt_after_ch9", 64'(drop_cnt_o), 64'd1);

    // Backpressure: 5 stalled cycles mid-packet
    send(mk(64'h5A00, 1'b1, 1'b0, 8'd5, 2'd2), 1, w);
    ast_ready_i = 1'b0;
    ast_valid_i = 1'b1;
    ast_data_i = 64'h5A01;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i = 1'b0;
    ast_channel_i = 8'd5;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready_low", 64'(ast_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    ast_ready_i = 1'b1;
    send(mk(64'h5A01, 1'b0, 1'b0, 8'd5, 2'd2), 1, w);
    send(mk(64'h5A02, 1'b0, 1'b1, 8'd5, 2'd2), 1, w);

    // Remap ch 5 mid-packet: current packet keeps dir 2, next gets dir 3
    send(mk(64'h5B00, 1'b1, 1'b0, 8'd5, 2'd2), 1, w);
    cfg_write(8'd5, 2'd3, 1'b1);
    send(mk(64'h5B01, 1'b0, 1'b0, 8'd5, 2'd2), 1, w);
    send(mk(64'h5B02, 1'b0, 1'b1, 8'd5, 2'd2), 1, w);
    send(mk(64'h5C00, 1'b1, 1'b0, 8'd5, 2'd3), 1, w);
    send(mk(64'h5C01, 1'b0, 1'b1, 8'd5, 2'd3), 1, w);

    // Write and lookup of ch 7 in the same cycle uses the old (disabled) entry
    cfg_wr_i = 1'b1; cfg_chan_i = 8'd7; cfg_dir_i = 2'd1; cfg_en_i = 1'b1;
    send(mk(64'h7700, 1'b1, 1'b1, 8'd7, 2'd1), 2, w);
    cfg_wr_i = 1'b0;
    chk("drop_cnt_same_cycle_write", 64'(drop_cnt_o), 64'd2);
    send(mk(64'h7701, 1'b1, 1'b1, 8'd7, 2'd1), 1, w);

    // Non-sop beat in IDLE, then single-beat sop+eop on ch 1
    send(mk(64'hE000, 1'b0, 1'b0, 8'd1, 2'd1), 2, w);
    send(mk(64'h1100, 1'b1, 1'b1, 8'd1, 2'd1), 1, w);
    chk("err_cnt_after_idle_beat", 64'(err_cnt_o), 64'd1);

    // Stray sop inside a packet is forwarded as data and counted
    send(mk(64'h1200, 1'b1, 1'b0, 8'd1, 2'd1), 1, w);
    send(mk(64'h1201, 1'b1, 1'b1, 8'd1, 2'd1), 1, w);
    chk("err_cnt_after_stray_sop", 64'(err_cnt_o), 64'd2);

    // Back-to-back single-beat packets with no bubble
    send(mk(64'h1300, 1'b1, 1'b1, 8'd1, 2'd1), 1, w);
    chk("b2b_first_no_wait", 64'(w), 64'd0);
    send(mk(64'h1400, 1'b1, 1'b1, 8'd1, 2'd1), 1, w);
    chk("b2b_second_no_wait", 64'(w), 64'd0);

    // Error counter saturates at all ones
    for (int i = 0; i < 20; i++) send(mk(64'hEE00 + 64'(i), 1'b0, 1'b0, 8'd1, 2'd1), 0, w);
    chk("err_cnt_saturated", 64'(err_cnt_o), 64'hF);
    chk("drop_cnt_unchanged", 64'(drop_cnt_o), 64'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);

    // Reset mid-packet clears outputs and table
    send(mk(64'h5D00, 1'b1, 1'b0, 8'd5, 2'd3), 1, w);
    send(mk(64'h5D01, 1'b0, 1'b0, 8'd5, 2'd3), 1, w);
    rst_ni = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(mk(64'h5E00 + 64'(i), i == 0, i == 2, 8'd5, 2'd3), 2, w);
    chk("drop_cnt_after_reset", 64'(drop_cnt_o), 64'd1);
    chk("err_cnt_after_reset", 64'(err_cnt_o), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained_final", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
